ocimem_arbiter: RTL

OCIMEM_ARBITER -- requirements
Module: ocimem_arbiter

---
 rtl/ocimem_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ocimem_arbiter.sv
// Arbitrates a single-port OCI RAM between a CPU slave port and JTAG debug actions.
// Define OCIMEM_ARBITER_JTAG_PRIO_EN to make JTAG win every tie instead of round-robin.
module ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              ovf_clr,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    output logic              cpu_waitrequest,
    output logic [31:0]       cpu_readdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_busy,
    output logic              jtag_ovf
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CPU_RD  = 2'd1;
    localparam logic [1:0] JTAG_RD = 2'd2;

    localparam logic [1:0] OP_RD_NOINC = 2'd0;
    localparam logic [1:0] OP_RD_INC   = 2'd1;
    localparam logic [1:0] OP_WR       = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              slotFull_q, slotFull_d;
    logic [1:0]        slotOp_q, slotOp_d;
    logic [31:0]       slotData_q, slotData_d;
    logic [ADDR_W-1:0] jtagAddr_q, jtagAddr_d;
    logic [31:0]       monDReg_q, monDReg_d;
    logic              jtagOvf_q, jtagOvf_d;
    logic              lastJtag_q, lastJtag_d;

    logic       cpuReq;
    logic       grantCpu;
    logic       grantJtag;
    logic       jtagIsWr;
    logic       jtagDone;
    logic       pulseAny;
    logic       ovfSet;
    logic [1:0] newOp;
    logic       unusedJdo;

    assign unusedJdo = ^{jdo[37:35], jdo[1:0]};
    assign cpuReq    = cpu_read | cpu_write;
    assign jtagIsWr  = (slotOp_q == OP_WR);

    // Grants exist only in IDLE and are suppressed while reset is held.
    always_comb begin
        grantCpu  = 1'b0;
        grantJtag = 1'b0;
        if (reset_n && state_q == IDLE) begin
            if (cpuReq && slotFull_q) begin
`ifdef OCIMEM_ARBITER_JTAG_PRIO_EN
                grantJtag = 1'b1;
`else
                grantJtag = ~lastJtag_q;
                grantCpu  = lastJtag_q;
`endif
            end else begin
                grantCpu  = cpuReq;
                grantJtag = slotFull_q;
            end
        end
    end

    assign jtagDone = (grantJtag & jtagIsWr) | (state_q == JTAG_RD);

    assign ram_we          = (grantCpu & cpu_write) | (grantJtag & jtagIsWr);
    assign ram_re          = (grantCpu & ~cpu_write) | (grantJtag & ~jtagIsWr);
    assign ram_addr        = grantJtag ? jtagAddr_q : cpu_address;
    assign ram_wdata       = grantJtag ? slotData_q : cpu_writedata;
    assign cpu_waitrequest = ~((grantCpu & cpu_write) | (reset_n & (state_q == CPU_RD)));
    assign cpu_readdata    = ram_rdata;
    assign MonDReg         = monDReg_q;
    assign jtag_busy       = slotFull_q | (state_q == JTAG_RD);
    assign jtag_ovf        = jtagOvf_q;

    always_comb begin
        state_d    = state_q;
        slotFull_d = slotFull_q;
        slotOp_d   = slotOp_q;
        slotData_d = slotData_q;
        jtagAddr_d = jtagAddr_q;
        monDReg_d  = monDReg_q;
        lastJtag_d = lastJtag_q;
        ovfSet     = 1'b0;
        newOp      = OP_RD_INC;
        pulseAny   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

        case (state_q)
            IDLE: begin
                if (grantCpu && !cpu_write) begin
                    state_d = CPU_RD;
                end else if (grantJtag && !jtagIsWr) begin
                    state_d = JTAG_RD;
                end
            end
            CPU_RD:  state_d = IDLE;
            JTAG_RD: begin
                state_d   = IDLE;
                monDReg_d = ram_rdata;
            end
            default: state_d = IDLE;
        endcase

        if (grantCpu) begin
            lastJtag_d = 1'b0;
        end
        if (grantJtag) begin
            lastJtag_d = 1'b1;
        end

        if (jtagDone) begin
            slotFull_d = 1'b0;
            if (slotOp_q != OP_RD_NOINC) begin
                jtagAddr_d = jtagAddr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end

        // A freshly accepted ocimem_a address overrides any increment from the op finishing now.
        if (take_action_ocimem_a) begin
            newOp  = OP_RD_NOINC;
            ovfSet = take_action_ocimem_b | take_no_action_ocimem_a;
        end else if (take_action_ocimem_b) begin
            newOp  = OP_WR;
            ovfSet = take_no_action_ocimem_a;
        end

        if (pulseAny) begin
            if (!slotFull_q || jtagDone) begin
                slotFull_d = 1'b1;
                slotOp_d   = newOp;
                if (newOp == OP_WR) begin
                    slotData_d = jdo[34:3];
                end
                if (take_action_ocimem_a) begin
                    jtagAddr_d = jdo[ADDR_W+1:2];
                end
            end else begin
                ovfSet = 1'b1;
            end
        end

        jtagOvf_d = ovfSet ? 1'b1 : (ovf_clr ? 1'b0 : jtagOvf_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            slotFull_q <= 1'b0;
            slotOp_q   <= OP_RD_NOINC;
            slotData_q <= '0;
            jtagAddr_q <= '0;
            monDReg_q  <= '0;
            jtagOvf_q  <= 1'b0;
            lastJtag_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            slotFull_q <= slotFull_d;
            slotOp_q   <= slotOp_d;
            slotData_q <= slotData_d;
            jtagAddr_q <= jtagAddr_d;
            monDReg_q  <= monDReg_d;
            jtagOvf_q  <= jtagOvf_d;
            lastJtag_q <= lastJtag_d;
        end
    end

endmodule
